// File: rtl/pad_bridge_writer.sv
// pad_bridge_writer: bridge-side writer for the per-controller contN_key / contN_joy words.
// Host writes land in shadow registers. The shadows are copied atomically to the outputs on a
// vsync rise or on a COMMIT write.
// Optional per-pad watchdog: define PAD_WATCHDOG_EN.
module pad_bridge_writer #(
    parameter int unsigned NUM_PADS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'hF700_0000,
    parameter logic [23:0] TIMEOUT   = 24'd2_000_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        bridge_wr,
    input  logic        bridge_rd,
    input  logic [31:0] bridge_addr,
    input  logic [31:0] bridge_wr_data,
    output logic [31:0] bridge_rd_data,
    input  logic        vsync,
    output logic [31:0] cont1_key,
    output logic [31:0] cont2_key,
    output logic [31:0] cont3_key,
    output logic [31:0] cont4_key,
    output logic [31:0] cont1_joy,
    output logic [31:0] cont2_joy,
    output logic [31:0] cont3_joy,
    output logic [31:0] cont4_joy,
    output logic [3:0]  pad_valid,
    output logic        upd
);

    localparam int unsigned MAX_PADS = 4;
    localparam int unsigned DW       = 32;
    localparam int unsigned CW       = 24;

    localparam logic [DW-1:0] KEY_NEUTRAL = 32'h0000_0000;
    localparam logic [DW-1:0] JOY_NEUTRAL = 32'h8080_8080;
    localparam logic [7:0]    OFF_COMMIT  = 8'h40;
    localparam logic [7:0]    OFF_STATUS  = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [MAX_PADS-1:0]   dirty_q, dirty_d;
    logic [MAX_PADS-1:0]   mask_q, mask_d;
    logic [MAX_PADS-1:0]   pad_valid_q, pad_valid_d;
    logic                  upd_q, upd_d;
    logic                  vsync_q, vsync_d;
    logic                  wdog_fired_q, wdog_fired_d;
    logic [DW-1:0]         rd_data_q, rd_data_d;
    logic [DW-1:0]         sh_key_q [MAX_PADS];
    logic [DW-1:0]         sh_key_d [MAX_PADS];
    logic [DW-1:0]         sh_joy_q [MAX_PADS];
    logic [DW-1:0]         sh_joy_d [MAX_PADS];
    logic [DW-1:0]         stage_key_q [MAX_PADS];
    logic [DW-1:0]         stage_key_d [MAX_PADS];
    logic [DW-1:0]         stage_joy_q [MAX_PADS];
    logic [DW-1:0]         stage_joy_d [MAX_PADS];
    logic [DW-1:0]         out_key_q [MAX_PADS];
    logic [DW-1:0]         out_key_d [MAX_PADS];
    logic [DW-1:0]         out_joy_q [MAX_PADS];
    logic [DW-1:0]         out_joy_d [MAX_PADS];

    logic                  hit;
    logic [7:0]            offset;
    logic                  pad_reg_sel;
    logic [1:0]            reg_pad;
    logic                  reg_is_joy;
    logic                  commit_wr;
    logic                  status_rd;
    logic                  vsync_rise;
    logic                  enter_commit;
    logic [MAX_PADS-1:0]   pad_en;
    logic [MAX_PADS-1:0]   wr_pad;
    logic [MAX_PADS-1:0]   wd_fire;

    // Address decode of the bridge window
    assign hit         = (bridge_addr[31:8] == BASE_ADDR[31:8]);
    assign offset      = bridge_addr[7:0];
    assign pad_reg_sel = hit && (offset[7:5] == 3'b000) && (offset[1:0] == 2'b00);
    assign reg_pad     = offset[4:3];
    assign reg_is_joy  = offset[2];
    assign commit_wr   = bridge_wr && hit && (offset == OFF_COMMIT);
    assign status_rd   = bridge_rd && hit && (offset == OFF_STATUS);
    assign vsync_d     = vsync;
    assign vsync_rise  = vsync && !vsync_q;

    // Pads beyond NUM_PADS are never written and stay neutral
    for (genvar g = 0; g < MAX_PADS; g++) begin : g_pad_en
        assign pad_en[g] = (g < NUM_PADS);
    end

    // Per-pad write strobes for active pads
    always_comb begin
        wr_pad = '0;
        for (int n = 0; n < MAX_PADS; n++) begin
            wr_pad[n] = bridge_wr && pad_reg_sel && (reg_pad == 2'(n)) && pad_en[n];
        end
    end

`ifdef PAD_WATCHDOG_EN
    logic [CW-1:0]       wd_cnt_q [MAX_PADS];
    logic [CW-1:0]       wd_cnt_d [MAX_PADS];
    logic [MAX_PADS-1:0] wd_done_q, wd_done_d;

    // Saturating staleness counters. The pad fires once per timeout; a write re-arms it.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        wd_done_d = wd_done_q;
        wd_fire   = '0;
        for (int n = 0; n < MAX_PADS; n++) begin
            if (!pad_en[n] || wr_pad[n]) begin
                wd_cnt_d[n]  = '0;
                wd_done_d[n] = 1'b0;
            end else if (wd_cnt_q[n] != TIMEOUT) begin
                wd_cnt_d[n] = wd_cnt_q[n] + CW'(1);
            end else if (!wd_done_q[n]) begin
                wd_fire[n]   = 1'b1;
                wd_done_d[n] = 1'b1;
            end
        end
    end

    // Watchdog state registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < MAX_PADS; n++) begin
                wd_cnt_q[n] <= '0;
            end
            wd_done_q <= '0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            wd_done_q <= wd_done_d;
        end
    end
`else
    assign wd_fire = '0;
`endif

    // Commit FSM, shadow/staging/output datapath and read mux
    always_comb begin
        state_d      = state_q;
        dirty_d      = dirty_q;
        mask_d       = mask_q;
        upd_d        = 1'b0;
        pad_valid_d  = pad_valid_q;
        rd_data_d    = rd_data_q;
        wdog_fired_d = (wdog_fired_q && !status_rd) || (|wd_fire);
        sh_key_d     = sh_key_q;
        sh_joy_d     = sh_joy_q;
        stage_key_d  = stage_key_q;
        stage_joy_d  = stage_joy_q;
        out_key_d    = out_key_q;
        out_joy_d    = out_joy_q;
        enter_commit = 1'b0;

        unique case (state_q)
            ST_IDLE:   enter_commit = commit_wr;
            ST_PEND:   enter_commit = commit_wr || vsync_rise;
            ST_COMMIT: upd_d = 1'b1;
            default:   enter_commit = 1'b0;
        endcase

        // Publish the snapshot taken when the commit was triggered
        if (state_q == ST_COMMIT) begin
            for (int n = 0; n < MAX_PADS; n++) begin
                if (mask_q[n]) begin
                    out_key_d[n]   = stage_key_q[n];
                    out_joy_d[n]   = stage_joy_q[n];
                    pad_valid_d[n] = 1'b1;
                end
            end
        end

        // Snapshot the pre-write shadows so a colliding write is left for the next commit
        if (enter_commit) begin
            stage_key_d = sh_key_q;
            stage_joy_d = sh_joy_q;
            mask_d      = dirty_q & ~wd_fire;
            dirty_d     = '0;
        end

        for (int n = 0; n < MAX_PADS; n++) begin
            if (wr_pad[n]) begin
                if (reg_is_joy) begin
                    sh_joy_d[n] = bridge_wr_data;
                end else begin
                    sh_key_d[n] = bridge_wr_data;
                end
                dirty_d[n] = 1'b1;
            end
        end

        // A timeout overrides everything else for that pad
        for (int n = 0; n < MAX_PADS; n++) begin
            if (wd_fire[n]) begin
                sh_key_d[n]    = KEY_NEUTRAL;
                sh_joy_d[n]    = JOY_NEUTRAL;
                out_key_d[n]   = KEY_NEUTRAL;
                out_joy_d[n]   = JOY_NEUTRAL;
                pad_valid_d[n] = 1'b0;
                dirty_d[n]     = 1'b0;
            end
        end

        if (enter_commit) begin
            state_d = ST_COMMIT;
        end else if (|dirty_d) begin
            state_d = ST_PEND;
        end else begin
            state_d = ST_IDLE;
        end

        if (bridge_rd) begin
            if (pad_reg_sel) begin
                rd_data_d = reg_is_joy ? out_joy_q[reg_pad] : out_key_q[reg_pad];
            end else if (status_rd) begin
                rd_data_d = {26'd0, |dirty_q, wdog_fired_q, pad_valid_q};
            end else begin
                rd_data_d = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dirty_q      <= '0;
            mask_q       <= '0;
            pad_valid_q  <= '0;
            upd_q        <= 1'b0;
            vsync_q      <= 1'b0;
            wdog_fired_q <= 1'b0;
            rd_data_q    <= '0;
            for (int n = 0; n < MAX_PADS; n++) begin
                sh_key_q[n]    <= KEY_NEUTRAL;
                sh_joy_q[n]    <= JOY_NEUTRAL;
                stage_key_q[n] <= KEY_NEUTRAL;
                stage_joy_q[n] <= JOY_NEUTRAL;
                out_key_q[n]   <= KEY_NEUTRAL;
                out_joy_q[n]   <= JOY_NEUTRAL;
            end
        end else begin
            state_q      <= state_d;
            dirty_q      <= dirty_d;
            mask_q       <= mask_d;
            pad_valid_q  <= pad_valid_d;
            upd_q        <= upd_d;
            vsync_q      <= vsync_d;
            wdog_fired_q <= wdog_fired_d;
            rd_data_q    <= rd_data_d;
            sh_key_q     <= sh_key_d;
            sh_joy_q     <= sh_joy_d;
            stage_key_q  <= stage_key_d;
            stage_joy_q  <= stage_joy_d;
            out_key_q    <= out_key_d;
            out_joy_q    <= out_joy_d;
        end
    end

    assign cont1_key      = out_key_q[0];
    assign cont2_key      = out_key_q[1];
    assign cont3_key      = out_key_q[2];
    assign cont4_key      = out_key_q[3];
    assign cont1_joy      = out_joy_q[0];
    assign cont2_joy      = out_joy_q[1];
    assign cont3_joy      = out_joy_q[2];
    assign cont4_joy      = out_joy_q[3];
    assign pad_valid      = pad_valid_q;
    assign upd            = upd_q;
    assign bridge_rd_data = rd_data_q;

endmodule

// File: doc/pad_bridge_writer.md
# pad_bridge_writer

Bridge-side writer that produces the per-controller 32-bit `contN_key` / `contN_joy` words consumed by the in-core gamepad decoder. Host writes arrive on the APF bridge bus and land in shadow registers. The shadows are committed atomically on the next rising edge of `vsync` or on an explicit commit write, so a key word and its joy word always change together. A per-pad watchdog returns stale pads to neutral.

## Interface
- `NUM_PADS`, 4: active controllers, 1..4; pads beyond this are tied neutral.
- `BASE_ADDR`, 32'hF700_0000: bridge window base; decode is `bridge_addr[31:8] == BASE_ADDR[31:8]`.
- `TIMEOUT`, 24'd2_000_000: watchdog limit in `clk_sys` cycles.

- `clk_sys` in 1: system clock; all logic is single-domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `bridge_wr` in 1: write strobe, one cycle per write.
- `bridge_rd` in 1: read strobe.
- `bridge_addr` in 32: byte address.
- `bridge_wr_data` in 32: write data.
- `bridge_rd_data` out 32: read data, valid one cycle after `bridge_rd`.
- `vsync` in 1: frame sync, `clk_sys` domain; its rising edge triggers a commit.
- `cont1_key`..`cont4_key` out 32 each: committed key words (pad_type in [31:28]).
- `cont1_joy`..`cont4_joy` out 32 each: committed analog words.
- `pad_valid` out 4: pad has committed data that has not timed out.
- `upd` out 1: one-cycle pulse on every commit.

## Operation
- Register map (offsets from the base):
  - Pad n key at 0x00+8n, pad n joy at 0x04+8n, for n = 0..3.
  - COMMIT at 0x40: any write triggers a commit.
  - STATUS at 0x44, read-only: {26'b0, pending, wdog_fired_any, pad_valid[3:0]}.
- Neutral values: key = 32'h0000_0000; joy = 32'h8080_8080.
- Writes:
  - A write to a pad register updates that shadow and sets `dirty[n]`.
  - Writes to pads ≥ `NUM_PADS` or to unmapped offsets are ignored.
- State machine with states IDLE, PEND and COMMIT:
  - IDLE -> PEND on any shadow write.
  - PEND -> COMMIT on a `vsync` rise (`vsync` = 1 and `vsync_q` = 0) or a COMMIT write.
  - COMMIT lasts one cycle. It copies every dirty shadow to the outputs, sets `pad_valid[n]` for each dirty n, clears `dirty`, pulses `upd`, then returns to IDLE.
  - A COMMIT write in IDLE still pulses `upd`; outputs are unchanged.
- Simultaneous shadow write and commit trigger in the same cycle:
  - The write lands in the shadow but is excluded from this commit.
  - Its `dirty` bit survives, and the FSM goes to PEND after COMMIT.
- A commit trigger while in COMMIT is absorbed (no second pulse).
- Reads:
  - Pad offsets return the committed (output) values, not the shadows.
  - STATUS returns as above; anything else returns 0.
- Reset (`reset_n` low, asynchronous):
  - All outputs go neutral; `pad_valid` = 0, `upd` = 0, `bridge_rd_data` = 0.
  - Shadows go neutral, `dirty` = 0, FSM = IDLE, watchdog counters = 0, `vsync_q` = 0.
  - A reset mid-commit discards everything.

## Timing
- Shadow write at edge N: visible to a commit at edge N+1 or later.
- Commit trigger sampled at edge M: outputs and `upd` change at edge M+1.
- Write-to-output latency: 2 cycles minimum (write N, COMMIT write N+1, outputs N+2).
- Read latency: 1 cycle; `bridge_rd_data` holds its value until the next read.
- The first `vsync` sample after reset cannot produce a rise, because `vsync_q` resets to 0 and `vsync` is assumed low at reset release; a high `vsync` at release counts as a rise.

## Configuration
- `PAD_WATCHDOG_EN` defined:
  - Each pad n < `NUM_PADS` has a 24-bit counter that clears on any write to that pad and otherwise increments, saturating at `TIMEOUT`.
  - On reaching `TIMEOUT`, the next cycle forces the output key/joy and shadow key/joy to neutral, clears `pad_valid[n]` and `dirty[n]`, and sets the sticky `wdog_fired_any`, which clears on a STATUS read.
  - A write in the same cycle as expiry wins: the counter clears and no timeout occurs.
- `PAD_WATCHDOG_EN` undefined: no counters; `pad_valid[n]` stays set after the first commit until reset; `wdog_fired_any` reads 0.

## Test plan
- Reset: hold `reset_n` = 0 -> all `contN_key` = 0, all `contN_joy` = 32'h8080_8080, `pad_valid` = 0, STATUS read = 0.
- Atomic update: write pad0 key = 32'h1000_0011 and joy = 32'h40C0_8080, with no trigger for 100 cycles -> outputs stay neutral. Then a `vsync` rise -> both words update on the same edge, `upd` pulses once, `pad_valid` = 4'b0001.
- Collision: pad1 key write coincides with a COMMIT write -> the value is not committed this time, STATUS pending = 1, and the next `vsync` rise commits it.
- `NUM_PADS` = 2: writes to pad 3 key -> `cont4_key` stays 0 and the read returns 0.
- Readback: after committing pad2 joy = 32'h1234_5678, `bridge_rd` at 0x14 -> next cycle `bridge_rd_data` = 32'h1234_5678.
- Watchdog (`PAD_WATCHDOG_EN`, `TIMEOUT` = 100): commit pad0, then no writes for 100 cycles -> `cont1_key` = 0, `cont1_joy` = 32'h8080_8080, `pad_valid[0]` = 0, STATUS bit4 = 1 and then clears after that read.
